// File: rtl/gcd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gcd_pkg
// Description : Shared types, defaults and helpers for the GCD scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
package gcd_pkg;

  // Default operand/result width
  localparam int DEF_W = 16;

  // Scheduler job phases
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_SETTLE = 3'd2,
    S_BUSY   = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  // Ceiling log2, never less than 1 so that a vector always has a bit
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    if (r < 1) r = 1;
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/gcd_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module      : gcd_scheduler_if
// Description : Requester-side bus of the GCD scheduler. The master side is
//               the requester population, the slave side is the scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
interface gcd_scheduler_if import gcd_pkg::*; #(
  parameter int N = 4,
  parameter int W = DEF_W
);
  logic [N-1:0]   req_i;
  logic [N*W-1:0] zahl1_i;
  logic [N*W-1:0] zahl2_i;
  logic [N-1:0]   gnt_o;
  logic [N-1:0]   ack_o;
  logic [W-1:0]   res_o;
  logic           err_o;
  logic           busy_o;

  modport master (
    output req_i, zahl1_i, zahl2_i,
    input  gnt_o, ack_o, res_o, err_o, busy_o
  );

  modport slave (
    input  req_i, zahl1_i, zahl2_i,
    output gnt_o, ack_o, res_o, err_o, busy_o
  );
endinterface
`default_nettype wire

// File: rtl/gcd_scheduler_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick
// Description : Combinational round-robin picker. The requester at ptr_i is
//               the first candidate, then ptr_i+1 and so on, wrapping at N.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick import gcd_pkg::*; #(
  parameter int N = 4,
  localparam int IW = clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  // Scan from the farthest candidate back to ptr_i so the nearest one wins
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      int j;
      j = int'(ptr_i) + k;
      if (j >= N) j = j - N;
      if (req_i[j]) begin
        gnt_o    = '0;
        gnt_o[j] = 1'b1;
        idx_o    = IW'(j);
        any_o    = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/gcd_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : gcd_scheduler
// Description : Shares one GCD core among N requesters with round-robin
//               arbitration, result return and a watchdog abort.
// Revision    : 1.0 - initial release
// ============================================================================
module gcd_scheduler import gcd_pkg::*; #(
  parameter int N       = 4,
  parameter int W       = DEF_W,
  parameter int TIMEOUT = 1024
) (
  input  logic          clk,
  input  logic          rst,
  gcd_scheduler_if.slave bus,
  output logic          core_start_o,
  output logic [W-1:0]  core_zahl1_o,
  output logic [W-1:0]  core_zahl2_o,
  input  logic          core_valid_i,
  input  logic [W-1:0]  core_erg_i
);

  localparam int IW  = clog2(N);
  localparam int WDW = clog2(TIMEOUT + 1);
  localparam logic [WDW-1:0] WD_LIMIT = WDW'(TIMEOUT);
  localparam logic [IW-1:0]  LAST_IDX = IW'(N - 1);

  state_t         state_q, state_d;
  logic [N-1:0]   gnt_q, gnt_d;
  logic [IW-1:0]  owner_q, owner_d;
  logic [IW-1:0]  ptr_q, ptr_d;
  logic [WDW-1:0] wd_q, wd_d;
  logic [W-1:0]   opa_q, opa_d;
  logic [W-1:0]   opb_q, opb_d;
  logic [W-1:0]   res_q, res_d;
  logic           err_q, err_d;

  logic [N-1:0]   pick_gnt;
  logic [IW-1:0]  pick_idx;
  logic           pick_any;

  rr_pick #(.N(N)) u_rr_pick (
    .req_i (bus.req_i),
    .ptr_i (ptr_q),
    .gnt_o (pick_gnt),
    .idx_o (pick_idx),
    .any_o (pick_any)
  );

  // State, ownership, watchdog and data registers; reset drops any job
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      gnt_q   <= '0;
      owner_q <= '0;
      ptr_q   <= '0;
      wd_q    <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      res_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      wd_q    <= wd_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      res_q   <= res_d;
      err_q   <= err_d;
    end
  end

  // Job sequencing: grant, start, mask stale valid, wait/abort, acknowledge
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    wd_d    = wd_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    res_d   = res_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (pick_any) begin
          gnt_d   = pick_gnt;
          owner_d = pick_idx;
          opa_d   = bus.zahl1_i[pick_idx*W +: W];
          opb_d   = bus.zahl2_i[pick_idx*W +: W];
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        state_d = S_SETTLE;
      end
      S_SETTLE: begin
        // valid may still be high from the previous job; ignore it here
        wd_d    = '0;
        state_d = S_BUSY;
      end
      S_BUSY: begin
        wd_d = wd_q + WDW'(1);
        if (core_valid_i) begin
          res_d   = core_erg_i;
          err_d   = 1'b0;
          state_d = S_DONE;
        end else if (wd_q == WD_LIMIT) begin
          res_d   = '0;
          err_d   = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        ptr_d   = (owner_q == LAST_IDX) ? '0 : owner_q + IW'(1);
        gnt_d   = '0;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus.gnt_o    = gnt_q;
  assign bus.ack_o    = (state_q == S_DONE) ? gnt_q : '0;
  assign bus.res_o    = res_q;
  assign bus.err_o    = err_q;
  assign bus.busy_o   = (state_q != S_IDLE);
  assign core_start_o = (state_q == S_LOAD);
  assign core_zahl1_o = opa_q;
  assign core_zahl2_o = opb_q;

endmodule
`default_nettype wire

// File: tb/tb_gcd_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_gcd_scheduler
// Description : Self-checking bench for gcd_scheduler with a behavioural GCD
//               core and an expected-result scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gcd_scheduler;
  import gcd_pkg::*;

  localparam int N   = 4;
  localparam int W   = 16;
  localparam int TO  = 8;
  localparam int LAT = 5;

  typedef struct {
    int         idx;
    logic [W-1:0] res;
    logic       err;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  gcd_scheduler_if #(.N(N), .W(W)) bus ();

  logic         core_start;
  logic [W-1:0] core_a, core_b;
  logic         core_valid;
  logic [W-1:0] core_erg;

  gcd_scheduler #(.N(N), .W(W), .TIMEOUT(TO)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus.slave),
    .core_start_o (core_start),
    .core_zahl1_o (core_a),
    .core_zahl2_o (core_b),
    .core_valid_i (core_valid),
    .core_erg_i   (core_erg)
  );

  // requester side: request held while more jobs are ordered than acked
  logic [W-1:0] opa [N];
  logic [W-1:0] opb [N];
  int issued [N];
  int done_cnt [N];

  always_comb begin
    bus.req_i   = '0;
    bus.zahl1_i = '0;
    bus.zahl2_i = '0;
    for (int i = 0; i < N; i++) begin
      bus.req_i[i]          = (issued[i] > done_cnt[i]);
      bus.zahl1_i[i*W +: W] = opa[i];
      bus.zahl2_i[i*W +: W] = opb[i];
    end
  end

  function automatic logic [W-1:0] gcd_f(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] x, y, t;
    x = a;
    y = b;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  // behavioural core: valid is a level that survives into the next job's
  // LOAD/SETTLE, then drops; the new result appears LAT edges after start
  bit           hang;
  int           m_cnt;
  bit           m_drop;
  logic [W-1:0] m_pend;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      core_valid <= 1'b0;
      core_erg   <= '0;
      m_cnt      <= 0;
      m_drop     <= 1'b0;
      m_pend     <= '0;
    end else if (core_start) begin
      m_pend <= gcd_f(core_a, core_b);
      m_cnt  <= LAT;
      m_drop <= 1'b1;
    end else begin
      if (m_drop) begin
        m_drop     <= 1'b0;
        core_valid <= 1'b0;
      end
      if (m_cnt > 0) begin
        m_cnt <= m_cnt - 1;
        if (m_cnt == 1 && !hang) begin
          core_valid <= 1'b1;
          core_erg   <= m_pend;
        end
      end
    end
  end

  int start_cnt = 0;
  always @(posedge clk) if (core_start) start_cnt <= start_cnt + 1;

  bit multi_gnt = 1'b0;
  always @(negedge clk) if (!$onehot0(bus.gnt_o)) multi_gnt <= 1'b1;

  exp_t sb [$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic push(input int idx, input logic [W-1:0] res, input logic err);
    exp_t e;
    e.idx = idx;
    e.res = res;
    e.err = err;
    sb.push_back(e);
  endtask

  task automatic wait_gnt(input string tag, input logic [N-1:0] exp_g, input int bound);
    for (int c = 0; c < bound; c++) begin
      @(negedge clk);
      if (bus.gnt_o != 0) break;
    end
    chk(tag, 32'(bus.gnt_o), 32'(exp_g));
  endtask

  task automatic wait_ack(input string tag, input int bound, output int lat);
    bit   got;
    exp_t e;
    got = 1'b0;
    lat = 0;
    for (int c = 1; c <= bound && !got; c++) begin
      @(negedge clk);
      if (bus.ack_o != 0) begin
        got = 1'b1;
        lat = c;
      end
    end
    checks++;
    assert (got) else begin
      errors++;
      $error("FAIL %s_ack observed=none expected=ack within %0d cycles", tag, bound);
    end
    if (got) begin
      checks++;
      assert (sb.size() != 0) else begin
        errors++;
        $error("FAIL %s_sb observed=ack %0h expected=no ack", tag, bus.ack_o);
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk({tag, "_vec"}, 32'(bus.ack_o), 32'(1) << e.idx);
        chk({tag, "_res"}, 32'(bus.res_o), 32'(e.res));
        chk({tag, "_err"}, 32'(bus.err_o), 32'(e.err));
        done_cnt[e.idx]++;
      end
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_gnt"},   32'(bus.gnt_o), 0);
    chk({tag, "_ack"},   32'(bus.ack_o), 0);
    chk({tag, "_res"},   32'(bus.res_o), 0);
    chk({tag, "_err"},   32'(bus.err_o), 0);
    chk({tag, "_busy"},  32'(bus.busy_o), 0);
    chk({tag, "_start"}, 32'(core_start), 0);
    chk({tag, "_z1"},    32'(core_a), 0);
    chk({tag, "_z2"},    32'(core_b), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout observed=no finish expected=finish");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int lat;
    int s0;
    for (int i = 0; i < N; i++) begin
      opa[i] = '0; opb[i] = '0; issued[i] = 0; done_cnt[i] = 0;
    end
    hang = 1'b0;

    // reset state
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    // simultaneous requests 0 and 2 with ptr=0
    opa[0] = 12; opb[0] = 8;
    opa[2] = 35; opb[2] = 21;
    push(0, 4, 1'b0);
    push(2, 7, 1'b0);
    issued[0]++; issued[2]++;
    wait_ack("sim0", 40, lat);
    chk("sim0_lat", lat, 8);
    wait_ack("sim2", 40, lat);
    chk("sim2_gap", lat, 9);

    // single request on requester 3 (stale valid from previous job present)
    @(negedge clk);
    s0 = start_cnt;
    opa[3] = 48; opb[3] = 18;
    push(3, 6, 1'b0);
    issued[3]++;
    wait_gnt("single_gnt", 4'b1000, 10);
    chk("single_start", 32'(core_start), 1);
    chk("single_z1", 32'(core_a), 48);
    chk("single_z2", 32'(core_b), 18);
    chk("single_busy", 32'(bus.busy_o), 1);
    wait_ack("single", 40, lat);
    chk("single_lat", lat, LAT + 2);
    @(negedge clk);
    chk("single_ack_clr", 32'(bus.ack_o), 0);
    chk("single_res_hold", 32'(bus.res_o), 6);
    chk("single_idle", 32'(bus.busy_o), 0);
    chk("single_starts", start_cnt - s0, 1);

    // fairness: all four requesters want two jobs each
    for (int i = 0; i < N; i++) begin
      opa[i] = W'(12 * (i + 1));
      opb[i] = W'(18 * (i + 1));
      issued[i] += 2;
    end
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < N; i++) push(i, W'(6 * (i + 1)), 1'b0);
    for (int j = 0; j < 8; j++) begin
      wait_ack("fair", 40, lat);
      if (j > 0) chk("fair_gap", lat, 9);
    end

    // timeout: the core never answers
    @(negedge clk);
    hang = 1'b1;
    opa[1] = 9; opb[1] = 6;
    push(1, 0, 1'b1);
    issued[1]++;
    wait_gnt("to_gnt", 4'b0010, 10);
    wait_ack("to", 40, lat);
    chk("to_lat", lat, TO + 3);
    hang = 1'b0;
    push(1, 3, 1'b0);
    issued[1]++;
    wait_ack("after_to", 40, lat);
    chk("after_to_gap", lat, 9);

    // stale valid held high through LOAD/SETTLE with the old result 3
    @(negedge clk);
    chk("stale_pre", 32'(core_valid), 1);
    opa[0] = 100; opb[0] = 75;
    push(0, 25, 1'b0);
    issued[0]++;
    wait_gnt("stale_gnt", 4'b0001, 10);
    wait_ack("stale", 40, lat);
    chk("stale_lat", lat, LAT + 2);

    // reset mid-BUSY: ptr=1 picks requester 1 before reset, 0 after
    @(negedge clk);
    opa[0] = 30; opb[0] = 12;
    opa[1] = 14; opb[1] = 21;
    issued[0]++; issued[1]++;
    wait_gnt("pre_rst_gnt", 4'b0010, 10);
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    #1 chk_all_zero("midrst");
    sb.delete();
    push(0, 6, 1'b0);
    push(1, 7, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    wait_gnt("post_rst_gnt", 4'b0001, 10);
    wait_ack("post_rst0", 40, lat);
    chk("post_rst0_lat", lat, LAT + 2);
    wait_ack("post_rst1", 40, lat);
    chk("post_rst1_gap", lat, 9);

    // global properties
    @(negedge clk);
    chk("onehot_gnt", 32'(multi_gnt), 0);
    chk("total_starts", start_cnt, 17);
    chk("sb_empty", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
